// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative HI/LO multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MSUB accumulate ops.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Signed ops work on magnitudes and fix the signs up at the end.
    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic logic op_is_iter(input md_op_e op);
`ifdef MULDIV_MADD_EN
        return (op != MD_MTHI) && (op != MD_MTLO);
`else
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring shift-subtract divide step.
// Multiply keeps {acc, multiplier} in {hi, lo}; divide keeps {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        div_shift = {hi_in, lo_in[WIDTH-1]};
        // Remainder stays below the divisor, so the difference always fits WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - operand;
        if (is_div) begin
            if (div_shift >= {1'b0, operand}) begin
                hi_out = div_diff;
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = div_shift[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = mul_sum[WIDTH:1];
            lo_out = {mul_sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine owning HI/LO, with Busy/Done/Stall pipeline handshake.
// Optional: define MULDIV_MADD_EN to enable MADD/MSUB accumulate into {HI,LO}.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hilo_read,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int N_ITER = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    generate
        if ((WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
            $error("STEPS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    md_op_e           op_reg;
    logic [WIDTH-1:0] operand_reg, work_hi_reg, work_lo_reg, a_raw_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             neg_q_reg, neg_r_reg, div_zero_reg, done_reg;

    md_op_e           op_in;
    logic             accept, accept_iter, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in       = md_op_e'(op);
    assign accept      = (state_reg == ST_IDLE) && start && !flush;
    assign accept_iter = accept && op_is_iter(op_in);
    assign a_neg       = op_is_signed(op_in) && a[WIDTH-1];
    assign b_neg       = op_is_signed(op_in) && b[WIDTH-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept_iter) state_next = ST_RUN;
            ST_RUN: begin
                if (flush)                       state_next = ST_IDLE;
                else if (cnt_reg == CNT_W'(1))   state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Iteration chain: STEPS_PER_CYCLE steps evaluated back to back each clock.
    logic             run_is_div;
    logic [WIDTH-1:0] hi_chain [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] lo_chain [0:STEPS_PER_CYCLE];

    assign run_is_div  = op_is_div(op_reg);
    assign hi_chain[0] = work_hi_reg;
    assign lo_chain[0] = work_lo_reg;

    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            muldiv_step #(.WIDTH(WIDTH)) u_step (
                .is_div  (run_is_div),
                .operand (operand_reg),
                .hi_in   (hi_chain[gi]),
                .lo_in   (lo_chain[gi]),
                .hi_out  (hi_chain[gi+1]),
                .lo_out  (lo_chain[gi+1])
            );
        end
    endgenerate

    logic [2*WIDTH-1:0] prod_raw, prod_signed;
    logic [WIDTH-1:0]   quot, rem, commit_hi, commit_lo;

    always_comb begin
        prod_raw    = {work_hi_reg, work_lo_reg};
        prod_signed = neg_q_reg ? -prod_raw : prod_raw;
        quot        = neg_q_reg ? -work_lo_reg : work_lo_reg;
        rem         = neg_r_reg ? -work_hi_reg : work_hi_reg;
        commit_hi   = prod_signed[2*WIDTH-1:WIDTH];
        commit_lo   = prod_signed[WIDTH-1:0];
        case (op_reg)
            MD_DIV, MD_DIVU: begin
                // Divide by zero bypasses the sign fix so HI returns the raw dividend.
                if (div_zero_reg) begin
                    commit_hi = a_raw_reg;
                    commit_lo = '1;
                end else begin
                    commit_hi = rem;
                    commit_lo = quot;
                end
            end
`ifdef MULDIV_MADD_EN
            MD_MADD: {commit_hi, commit_lo} = {hi_reg, lo_reg} + prod_signed;
            MD_MSUB: {commit_hi, commit_lo} = {hi_reg, lo_reg} - prod_signed;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            op_reg       <= MD_MULT;
            operand_reg  <= '0;
            work_hi_reg  <= '0;
            work_lo_reg  <= '0;
            a_raw_reg    <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept && op_in == MD_MTHI) hi_reg <= a;
                    if (accept && op_in == MD_MTLO) lo_reg <= a;
                    if (accept_iter) begin
                        cnt_reg      <= CNT_W'(N_ITER);
                        op_reg       <= op_in;
                        operand_reg  <= op_is_div(op_in) ? b_mag : a_mag;
                        work_hi_reg  <= '0;
                        work_lo_reg  <= op_is_div(op_in) ? a_mag : b_mag;
                        a_raw_reg    <= a;
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= (b == '0);
                    end
                end
                ST_RUN: begin
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                    work_hi_reg <= hi_chain[STEPS_PER_CYCLE];
                    work_lo_reg <= lo_chain[STEPS_PER_CYCLE];
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi_reg   <= commit_hi;
                        lo_reg   <= commit_lo;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign stall  = busy && (start || hilo_read);
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized self-checking bench for muldiv_hilo_unit against an arithmetic reference model.
// Honours MULDIV_MADD_EN to choose the expected MADD/MSUB behaviour.
module tb_muldiv_hilo_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;
`ifdef MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, flush, hilo_read;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, stall;
    logic [W-1:0] hi_out, lo_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    muldiv_hilo_unit #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hilo_read (hilo_read),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_iter(input logic [2:0] o);
        return (o < 3'd4) || (MADD_EN && o >= 3'd6);
    endfunction

    // Architectural result of one op, from plain arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint     sp;
        logic [63:0] up;
        int         q, r;
        sp = longint'($signed(av)) * longint'($signed(bv));
        case (o)
            3'd0: {m_hi, m_lo} = sp;
            3'd1: begin
                up = 64'(av) * 64'(bv);
                {m_hi, m_lo} = up;
            end
            3'd2: begin
                if (bv == 0) begin
                    m_hi = av; m_lo = '1;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    m_hi = '0; m_lo = av;
                end else begin
                    q = $signed(av) / $signed(bv);
                    r = $signed(av) % $signed(bv);
                    m_lo = q; m_hi = r;
                end
            end
            3'd3: begin
                if (bv == 0) begin
                    m_hi = av; m_lo = '1;
                end else begin
                    m_lo = av / bv; m_hi = av % bv;
                end
            end
            3'd4: m_hi = av;
            3'd5: m_lo = av;
            3'd6: if (MADD_EN) {m_hi, m_lo} = {m_hi, m_lo} + sp;
            default: if (MADD_EN) {m_hi, m_lo} = {m_hi, m_lo} - sp;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        int k;
        bit saw_done;
        model_apply(o, av, bv);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (is_iter(o)) begin
            check_eq("busy_after_accept", busy, 1'b1);
            k = 0;
            while (done !== 1'b1 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            check_eq("latency", k, LAT);
            check_eq("busy_at_done", busy, 1'b0);
        end else begin
            check_eq("busy_nonit", busy, 1'b0);
            saw_done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (done === 1'b1) saw_done = 1'b1;
                @(posedge clk); #1;
            end
            check_eq("no_done_nonit", saw_done, 1'b0);
        end
        check_eq("hi", hi_out, m_hi);
        check_eq("lo", lo_out, m_lo);
        $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h (model hi=%h lo=%h)",
                 o, av, bv, hi_out, lo_out, m_hi, m_lo);
    endtask

    initial begin
        bit saw_done;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;
        int sel;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_read = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hi", hi_out, '0);
        check_eq("rst_lo", lo_out, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        check_eq("tp_mult_hi", hi_out, 32'hFFFF_FFFF);
        check_eq("tp_mult_lo", lo_out, 32'hFFFF_FFEB);
        do_op(3'd3, 32'd100, 32'd7);
        check_eq("tp_divu_lo", lo_out, 32'd14);
        check_eq("tp_divu_hi", hi_out, 32'd2);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check_eq("tp_div_lo", lo_out, 32'hFFFF_FFFD);
        check_eq("tp_div_hi", hi_out, 32'hFFFF_FFFF);
        do_op(3'd2, 32'd5, 32'd0);
        check_eq("tp_div0_hi", hi_out, 32'd5);
        check_eq("tp_div0_lo", lo_out, 32'hFFFF_FFFF);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("tp_ovf_lo", lo_out, 32'h8000_0000);
        check_eq("tp_ovf_hi", hi_out, 32'd0);

        // Stall while busy, rejected second start, then flush mid-run.
        @(negedge clk);
        op = 3'd0; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        hilo_read = 1'b1; start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd2;
        #1;
        check_eq("stall_hiloread", stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check_eq("stall_hold", stall, 1'b1);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0; hilo_read = 1'b0;
        check_eq("flush_busy", busy, 1'b0);
        check_eq("flush_stall", stall, 1'b0);
        check_eq("flush_hi", hi_out, m_hi);
        check_eq("flush_lo", lo_out, m_lo);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("flush_no_done", saw_done, 1'b0);
        $display("[TB] flush scenario hi=%h lo=%h", hi_out, lo_out);

        do_op(3'd4, 32'h1234_5678, 32'd0);
        check_eq("tp_mthi", hi_out, 32'h1234_5678);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hi", hi_out, '0);
        check_eq("arst_lo", lo_out, '0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] async reset mid-run hi=%h lo=%h busy=%b", hi_out, lo_out, busy);

        do_op(3'd4, 32'd0, 32'd0);
        do_op(3'd5, 32'h10, 32'd0);
        do_op(3'd6, 32'd2, 32'd3);
        check_eq("tp_madd_hi", hi_out, 32'd0);
        check_eq("tp_madd_lo", lo_out, MADD_EN ? 32'h16 : 32'h10);
        do_op(3'd4, 32'd0, 32'd0);
        do_op(3'd5, 32'h10, 32'd0);
        do_op(3'd7, 32'h20, 32'd1);
        check_eq("tp_msub_hi", hi_out, MADD_EN ? 32'hFFFF_FFFF : 32'd0);
        check_eq("tp_msub_lo", lo_out, MADD_EN ? 32'hFFFF_FFF0 : 32'h10);

        for (int n = 0; n < 60; n++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
            else if (sel == 3) rb = -(32'($urandom_range(1, 20)));
            do_op(ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

- Parametrised iterative multiply/divide engine that owns the HI/LO architectural registers.
- Sits in EX beside the ALU and replaces single-cycle HI/LO arithmetic with a multi-cycle shift-add/shift-subtract core.
- Exposes Busy, Done and Stall so the pipeline can hold mfhi/mflo and back-to-back HI/LO ops until the result is committed.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- STEPS_PER_CYCLE, 1: iteration steps per clock; must divide WIDTH (checked at elaboration).
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Start  in  1  request; Op/A/B sampled when Start=1 and unit not Busy.
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- A  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- B  in  WIDTH  rt operand (divisor / multiplier).
- Flush  in  1  abort any in-flight operation.
- HiLoRead  in  1  pipeline wants HI/LO this cycle (mfhi/mflo in EX).
- Busy  out  1  iterative operation in flight.
- Done  out  1  one-cycle pulse; HI/LO just committed.
- Stall  out  1  Busy & (Start | HiLoRead).
- Hi_out, Lo_out  out  WIDTH  registered HI/LO.

## Operation
- FSM: IDLE, RUN, FIX.
- IDLE + Start + Op in {0,1,2,3,6,7}: latch operands as magnitudes (signed ops), record result signs -> RUN, step counter = WIDTH/STEPS_PER_CYCLE.
- IDLE + Start + MTHI/MTLO: write A into HI/LO at the next edge; no Busy, no Done.
- RUN: STEPS_PER_CYCLE shift-add (mul) or restoring shift-subtract (div) steps per clock; counter decrements; at 0 -> FIX.
- FIX: apply sign correction, commit HI/LO, pulse Done -> IDLE.
- Multiply: {HI,LO} = 2*WIDTH-bit product; MULT signed, MULTU unsigned.
- Divide: LO = quotient, HI = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
- Divide by zero: HI = A, LO = all ones, normal latency.
- Signed overflow (A = most-negative, B = -1): LO = A, HI = 0.
- Start while Busy: not accepted, Stall=1, state untouched; requester must hold Start.
- Flush: RUN/FIX -> IDLE at next edge, HI/LO unchanged, no Done. Flush wins over a simultaneous commit in FIX. Flush with Start in IDLE: Start dropped.
- Async Rst low: IDLE, HI=LO=0, Busy=Done=0 immediately; counter cleared.

## Timing
- Start accepted at edge E0; Busy=1 after E0.
- HI/LO updated at edge E0+L, where L = WIDTH/STEPS_PER_CYCLE + 1 (33 for defaults). Done=1 and Busy=0 in the cycle after E0+L.
- A new Start is accepted in the same cycle Done is high.
- MTHI/MTLO: value visible on Hi_out/Lo_out one cycle after acceptance.
- Stall is combinational from Busy, Start and HiLoRead; all other outputs are registered.
- Reset values: Hi_out=0, Lo_out=0, Busy=0, Done=0, Stall=0.

## Configuration
- MULDIV_MADD_EN defined: MADD/MSUB perform a signed multiply, then in FIX set {HI,LO} = {HI,LO} ± product (2*WIDTH wrap-around), with the same latency as MULT.
- MULDIV_MADD_EN undefined: Op 6/7 are accepted as no-ops with no Busy, no Done and HI/LO unchanged; the accumulate adder is not synthesised.

## Structure
- Package muldiv_pkg holds the op enum (MD_MULT..MD_MSUB), the FSM state enum and the sign/special-case helper constants.
- Sub-module muldiv_step is combinational: one multiply/divide iteration step, instantiated STEPS_PER_CYCLE times in a chain inside the top.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 -> Done 33 cycles after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU A=100, B=7 -> LO=14, HI=2; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 -> HI=5, LO=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT, then HiLoRead=1 and a second Start at cycle 5 -> Stall=1 until Done, second op not accepted; Flush at cycle 10 -> Busy=0 next cycle, HI/LO keep previous values, no Done.
- MTHI A=0x12345678 -> Hi_out=0x12345678 next cycle, Busy stays 0. Then Rst low mid-RUN -> Hi_out=Lo_out=0, Busy=0 without waiting for a clock.
- With MULDIV_MADD_EN and HI:LO=0:0x10, MADD 2,3 -> LO=0x16, HI=0. MSUB 0x20,1 from 0:0x10 -> HI=0xFFFFFFFF, LO=0xFFFFFFF0. Without the macro, both leave HI/LO unchanged and Done stays 0.
